// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
//
// Stream demultiplexer. One valid/ready input stream is routed beat by beat to
// one of PORT_NUM output ports, chosen by the lowest set bit of dest_i.
// Each output port owns a single registered slot, so back-pressure is tracked
// per port. A stalled port never blocks beats bound for other ports. Beats
// with no destination bit set are accepted, discarded and counted in a
// saturating drop counter.
//
// Handshake semantics (both sides):
//   A beat transfers on a rising clk_i edge where valid and ready are both 1.
//   A producer holding valid=1 keeps its payload stable until the transfer.
//   ready_o never depends on valid_i.
//   valid_o[p] is never withdrawn before ready_i[p] takes the beat.
//
// Parameters
//   DATA_WIDTH  width of one data beat
//   PORT_NUM    number of output ports
//   CNT_WIDTH   width of the saturating drop counter
//
// Ports
//   clk_i       in   clock, all state on the rising edge
//   rst_i       in   asynchronous active-high reset
//   data_i      in   input beat
//   dest_i      in   destination vector; the lowest set bit wins
//   valid_i     in   input beat valid
//   ready_o     out  input beat may be accepted this cycle (combinational)
//   data_o      out  packed output data; port p at [(p+1)*DATA_WIDTH-1 : p*DATA_WIDTH]
//   valid_o     out  per-port output valid
//   ready_i     in   per-port downstream ready
//   drop_cnt_o  out  number of discarded beats, saturating at all-ones
// -----------------------------------------------------------------------------
module demux_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PORT_NUM   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic [PORT_NUM-1:0]            dest_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic [DATA_WIDTH*PORT_NUM-1:0] data_o,
  output logic [PORT_NUM-1:0]            valid_o,
  input  logic [PORT_NUM-1:0]            ready_i,
  output logic [CNT_WIDTH-1:0]           drop_cnt_o
);

  // ---------------------------------------------------------------------------
  // Destination decode
  // ---------------------------------------------------------------------------
  // Isolating the lowest set bit with x & -x yields a one-hot target vector
  // directly, so no index encode/decode is needed. Bit 0 has top priority.
  logic [PORT_NUM-1:0] dest_oh;
  logic                dest_none;

  assign dest_oh   = dest_i & (~dest_i + PORT_NUM'(1));
  assign dest_none = (dest_i == '0);

  // ---------------------------------------------------------------------------
  // Slot availability and input ready
  // ---------------------------------------------------------------------------
  // A slot is free when it is empty or its current beat leaves on this edge,
  // which lets a port consume and refill in the same cycle.
  logic [PORT_NUM-1:0] slot_free;

  assign slot_free = ~valid_o | ready_i;

  // Discards are always accepted; otherwise only the targeted slot matters,
  // so a stalled port cannot hold up beats aimed elsewhere.
  assign ready_o = dest_none | (|(dest_oh & slot_free));

  // ---------------------------------------------------------------------------
  // Transfer qualifiers
  // ---------------------------------------------------------------------------
  logic                accept;
  logic                drop;
  logic [PORT_NUM-1:0] load;
  logic [PORT_NUM-1:0] consume;

  assign accept  = valid_i & ready_o;
  assign drop    = accept & dest_none;
  assign load    = dest_oh & {PORT_NUM{accept}};
  assign consume = valid_o & ready_i;

  // ---------------------------------------------------------------------------
  // Per-port slots
  // ---------------------------------------------------------------------------
  // A refill takes precedence over a consume, so a port that hands off and
  // receives on the same edge stays valid with the new beat. data_o only
  // changes on a load, which keeps a stalled beat stable and leaves the last
  // value in place once the slot empties.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= '0;
      data_o  <= '0;
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (load[p]) begin
          valid_o[p]                           <= 1'b1;
          data_o[p*DATA_WIDTH +: DATA_WIDTH]   <= data_i;
        end else if (consume[p]) begin
          valid_o[p]                           <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter
  // ---------------------------------------------------------------------------
  // Saturates at all-ones so a long run of discards never wraps back to a
  // small, misleading value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (drop && (drop_cnt_o != '1)) begin
      drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // The decoded target is one-hot or empty.
  a_dest_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(dest_oh));

  // At most one port is loaded per edge: no multicast.
  a_single_load : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(load));

  // A discard never touches a port.
  a_drop_no_load : assert property (@(posedge clk_i) disable iff (rst_i)
    drop |-> (load == '0));

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_hold
    // A stalled output keeps valid high and its data stable.
    a_stall_hold : assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_o[g] && !ready_i[g])
        |=> (valid_o[g] && $stable(data_o[g*DATA_WIDTH +: DATA_WIDTH])));
  end

endmodule

// File: tb/tb_demux_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_stream
//
// Directed bench for demux_stream. Inputs are driven 1 ns after the rising
// edge and outputs are sampled at least 1 ns after it. A second instance with
// CNT_WIDTH=2 shares all inputs and is used only to observe counter
// saturation.
// -----------------------------------------------------------------------------
module tb_demux_stream;

  localparam int DW = 8;
  localparam int PN = 4;
  localparam int CW = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [DW-1:0]    data_i  = '0;
  logic [PN-1:0]    dest_i  = '0;
  logic             valid_i = 1'b0;
  logic [PN-1:0]    ready_i = '0;
  logic             ready_o;
  logic [DW*PN-1:0] data_o;
  logic [PN-1:0]    valid_o;
  logic [CW-1:0]    drop_cnt_o;

  logic             s_ready_o;
  logic [DW*PN-1:0] s_data_o;
  logic [PN-1:0]    s_valid_o;
  logic [1:0]       s_drop_cnt_o;

  demux_stream #(.DATA_WIDTH(DW), .PORT_NUM(PN), .CNT_WIDTH(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .data_i     (data_i),
    .dest_i     (dest_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .drop_cnt_o (drop_cnt_o)
  );

  demux_stream #(.DATA_WIDTH(DW), .PORT_NUM(PN), .CNT_WIDTH(2)) dut_sat (
    .clk_i      (clk),
    .rst_i      (rst),
    .data_i     (data_i),
    .dest_i     (dest_i),
    .valid_i    (valid_i),
    .ready_o    (s_ready_o),
    .data_o     (s_data_o),
    .valid_o    (s_valid_o),
    .ready_i    (ready_i),
    .drop_cnt_o (s_drop_cnt_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PN-1:0] d,
                       input logic [DW-1:0] x);
    valid_i = v;
    dest_i  = d;
    data_i  = x;
  endtask

  // Expected data for the throughput run, queued at send and popped on arrival.
  logic [DW-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    #2;
    check_val("rst_valid", 32'(valid_o), 32'h0);
    check_val("rst_data", data_o, 32'h0);
    check_val("rst_drop", 32'(drop_cnt_o), 32'h0);
    dest_i = 4'b0001;
    #1;
    check_val("rst_ready", 32'(ready_o), 32'h1);

    tick();
    rst = 1'b0;

    // Test 1: fill ports 0 and 2 under stall, drop one beat, then reset mid-cycle
    ready_i = 4'b0000;
    drive(1'b1, 4'b0001, 8'h11); tick();
    drive(1'b1, 4'b0100, 8'h22); tick();
    drive(1'b1, 4'b0000, 8'h33); tick();
    drive(1'b0, 4'b0000, 8'h00);
    check_val("t1_valid_pre", 32'(valid_o), 32'h5);
    check_val("t1_data_pre", data_o, 32'h0022_0011);
    check_val("t1_drop_pre", 32'(drop_cnt_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t1_valid_rst", 32'(valid_o), 32'h0);
    check_val("t1_drop_rst", 32'(drop_cnt_o), 32'h0);
    check_val("t1_data_rst", data_o, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Test 2: route to port 2
    ready_i = 4'b1111;
    drive(1'b1, 4'b0100, 8'hA5);
    #1;
    check_val("t2_ready", 32'(ready_o), 32'h1);
    tick();
    drive(1'b0, 4'b0000, 8'h00);
    check_val("t2_valid", 32'(valid_o), 32'h4);
    check_val("t2_data", 32'(data_o[23:16]), 32'hA5);
    tick();
    check_val("t2_drain", 32'(valid_o), 32'h0);

    // Test 3: lowest set bit wins
    drive(1'b1, 4'b1010, 8'h3C);
    tick();
    drive(1'b0, 4'b0000, 8'h00);
    check_val("t3_valid", 32'(valid_o), 32'h2);
    check_val("t3_data1", 32'(data_o[15:8]), 32'h3C);
    check_val("t3_data3", 32'(data_o[31:24]), 32'h00);
    tick();
    check_val("t3_drain", 32'(valid_o), 32'h0);

    // Test 4: back-pressure on port 2
    ready_i = 4'b1011;
    drive(1'b1, 4'b0100, 8'h5A);
    tick();
    check_val("t4_fill", 32'(valid_o), 32'h4);
    drive(1'b1, 4'b0001, 8'hC3);
    #1;
    check_val("t4_ready_p0", 32'(ready_o), 32'h1);
    tick();
    check_val("t4_valid_p0", 32'(valid_o), 32'h5);
    check_val("t4_data_p0", 32'(data_o[7:0]), 32'hC3);
    drive(1'b1, 4'b0100, 8'h77);
    #1;
    check_val("t4_ready_p2", 32'(ready_o), 32'h0);
    tick();
    check_val("t4_hold_data", 32'(data_o[23:16]), 32'h5A);
    check_val("t4_hold_valid", 32'(valid_o), 32'h4);
    ready_i = 4'b1111;
    #1;
    check_val("t4_ready_rel", 32'(ready_o), 32'h1);
    tick();
    drive(1'b0, 4'b0000, 8'h00);
    check_val("t4_refill_valid", 32'(valid_o), 32'h4);
    check_val("t4_refill_data", 32'(data_o[23:16]), 32'h77);
    tick();
    check_val("t4_drain", 32'(valid_o), 32'h0);

    // Test 5: 16 back-to-back beats to port 3
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'b1000, 8'(8'h40 + i));
      exp_q.push_back(8'(8'h40 + i));
      #1;
      check_val($sformatf("t5_ready_%0d", i), 32'(ready_o), 32'h1);
      tick();
      check_val($sformatf("t5_valid_%0d", i), 32'(valid_o), 32'h8);
      check_val($sformatf("t5_data_%0d", i), 32'(data_o[31:24]),
                32'(exp_q.pop_front()));
    end
    drive(1'b0, 4'b0000, 8'h00);
    tick();
    check_val("t5_drain", 32'(valid_o), 32'h0);

    // Test 6: five discards; the 2-bit counter saturates at 3
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'b0000, 8'(8'hE0 + i));
      #1;
      check_val($sformatf("t6_ready_%0d", i), 32'(ready_o), 32'h1);
      tick();
      check_val($sformatf("t6_valid_%0d", i), 32'(valid_o), 32'h0);
      check_val($sformatf("t6_cnt_%0d", i), 32'(drop_cnt_o), 32'(i));
      check_val($sformatf("t6_sat_%0d", i), 32'(s_drop_cnt_o),
                (i > 3) ? 32'h3 : 32'(i));
    end
    drive(1'b0, 4'b0000, 8'h00);
    tick();
    check_val("t6_cnt_final", 32'(drop_cnt_o), 32'h5);
    check_val("t6_sat_final", 32'(s_drop_cnt_o), 32'h3);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Runaway guard
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
